// File: rtl/or_tree_pipe.sv
// rtl/or_tree_pipe.sv - elastic pipelined OR/NOR reduction tree, one result bit per lane
module or_tree_pipe #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 1
) (
   input  logic                      clkpos,
   input  logic                      rstn,
   input  logic                      vdd,
   input  logic                      vss,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic                      in_inv,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS-1:0]       out_data,
   output logic [15:0]               tok_cnt
);
   // Pipeline depth follows from the operand width; derived, never overridden.
   localparam int LEVELS = $clog2(WIDTH);

   // Number of partial ORs per lane held at tree level k (level 0 is the raw input).
   function automatic int lvl_bits(input int k);
      return (WIDTH + (1 << k) - 1) >> k;
   endfunction

   // Bit offset of level k inside the flattened level bus.
   function automatic int lvl_off(input int k);
      int s;
      s = 0;
      for (int i = 0; i < k; i++) begin
         s += CHANNELS * lvl_bits(i);
      end
      return s;
   endfunction

   localparam int TOT = lvl_off(LEVELS) + CHANNELS;

   // All tree levels side by side; each stage reads the slice of the level before it.
   logic [TOT-1:0]    lvl_data;
   logic [LEVELS:0]   lvl_vld;
   logic [LEVELS:0]   lvl_inv;
   // lvl_acc[k]: stage k can take a token on the coming edge (empty or emptying).
   logic [LEVELS:1]   lvl_acc;
   logic              pg;
   logic [15:0]       tok_cnt_q;

   assign pg = vdd & ~vss;

   assign lvl_data[CHANNELS*WIDTH-1:0] = in_data;
   assign lvl_vld[0]                   = in_valid;
   assign lvl_inv[0]                   = in_inv;

   for (genvar k = 1; k <= LEVELS; k++) begin : gen_stage
      localparam int NI   = lvl_bits(k - 1);
      localparam int NO   = lvl_bits(k);
      localparam int OFSI = lvl_off(k - 1);
      localparam int OFSO = lvl_off(k);

      logic [CHANNELS*NI-1:0] src;
      logic [CHANNELS*NO-1:0] data_d;
      logic [CHANNELS*NO-1:0] data_q;
      logic                   vld_q;
      logic                   inv_q;

      assign src = lvl_data[OFSI +: CHANNELS*NI];

      // Pairwise OR of the previous level; an unpaired top bit passes straight through.
      always_comb begin
         data_d = '0;
         for (int c = 0; c < CHANNELS; c++) begin
            for (int j = 0; j < NO; j++) begin
               if (2*j + 1 < NI) begin
                  data_d[c*NO + j] = src[c*NI + 2*j] | src[c*NI + 2*j + 1];
               end else begin
                  data_d[c*NO + j] = src[c*NI + 2*j];
               end
            end
         end
      end

      // Stage register: flush on power loss, otherwise load whenever this slot frees up.
      always_ff @(posedge clkpos or negedge rstn) begin
         if (!rstn) begin
            vld_q  <= 1'b0;
            inv_q  <= 1'b0;
            data_q <= '0;
         end else if (!pg) begin
            vld_q <= 1'b0;
         end else if (lvl_acc[k]) begin
            vld_q <= lvl_vld[k-1];
            if (lvl_vld[k-1]) begin
               data_q <= data_d;
               inv_q  <= lvl_inv[k-1];
            end
         end
      end

      assign lvl_data[OFSO +: CHANNELS*NO] = data_q;
      assign lvl_vld[k]                    = vld_q;
      assign lvl_inv[k]                    = inv_q;

      if (k == LEVELS) begin : gen_last
         assign lvl_acc[k] = ~vld_q | out_ready;
      end else begin : gen_mid
         assign lvl_acc[k] = ~vld_q | lvl_acc[k+1];
      end
   end

   // Ready ripples back combinationally so a full pipe still streams at one token per cycle.
   assign in_ready  = rstn & pg & lvl_acc[1];
   assign out_valid = pg & lvl_vld[LEVELS];
   assign out_data  = lvl_data[lvl_off(LEVELS) +: CHANNELS] ^ {CHANNELS{lvl_inv[LEVELS]}};

   // Delivered-token counter; wraps naturally at 16 bits.
   always_ff @(posedge clkpos or negedge rstn) begin
      if (!rstn) begin
         tok_cnt_q <= 16'd0;
      end else if (out_valid && out_ready) begin
         tok_cnt_q <= tok_cnt_q + 16'd1;
      end
   end

   assign tok_cnt = tok_cnt_q;

endmodule

// File: tb/tb_or_tree_pipe.sv
// tb/tb_or_tree_pipe.sv - self-checking bench for or_tree_pipe
module tb_or_tree_pipe;
   localparam int W  = 5;
   localparam int CH = 2;
   localparam int LV = 3;
   localparam logic [CH*W-1:0] ONE = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstn, vdd, vss;
   logic            in_valid, in_inv, out_ready;
   logic [CH*W-1:0] in_data;
   logic            in_ready, out_valid;
   logic [CH-1:0]   out_data;
   logic [15:0]     tok_cnt;

   logic            a_in_valid, a_in_inv, a_out_ready, a_in_ready, a_out_valid;
   logic [3:0]      a_in_data;
   logic [0:0]      a_out_data;
   logic [15:0]     a_tok_cnt;

   logic            b_in_valid, b_in_inv, b_out_ready, b_in_ready, b_out_valid;
   logic [1:0]      b_in_data;
   logic [0:0]      b_out_data;
   logic [15:0]     b_tok_cnt;

   or_tree_pipe #(.WIDTH(W), .CHANNELS(CH)) u_dut (
      .clkpos(clk), .rstn(rstn), .vdd(vdd), .vss(vss),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .tok_cnt(tok_cnt)
   );

   or_tree_pipe #(.WIDTH(4), .CHANNELS(1)) u_w4 (
      .clkpos(clk), .rstn(rstn), .vdd(vdd), .vss(vss),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_inv(a_in_inv),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .tok_cnt(a_tok_cnt)
   );

   or_tree_pipe #(.WIDTH(2), .CHANNELS(1)) u_w2 (
      .clkpos(clk), .rstn(rstn), .vdd(vdd), .vss(vss),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_inv(b_in_inv),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .tok_cnt(b_tok_cnt)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result: each lane is nonzero-or-not, flipped by the token's NOR bit.
   function automatic logic [CH-1:0] ref_of(input logic [CH*W-1:0] d, input logic inv);
      logic [CH-1:0] r;
      for (int c = 0; c < CH; c++) r[c] = (d[c*W +: W] != '0) ^ inv;
      return r;
   endfunction

   typedef struct {
      logic [CH-1:0] d;
      int            t;
   } tok_t;

   tok_t        mq[$];
   int          edge_n = 0;
   logic [15:0] m_cnt  = 16'd0;

   // Model: in-order token queue with acceptance edge; head is visible LV edges after acceptance.
   always @(negedge clk) begin
      logic pg_s, e_ov, e_ir;
      if (!rstn) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_tok_cnt", tok_cnt, 0);
         chk("rst_out_data", out_data, 0);
         mq.delete();
         m_cnt = 16'd0;
      end else begin
         pg_s = vdd & ~vss;
         e_ov = pg_s && (mq.size() > 0) && (edge_n - mq[0].t >= LV);
         e_ir = pg_s && ((mq.size() < LV) || out_ready);
         chk("m_out_valid", out_valid, e_ov);
         chk("m_in_ready", in_ready, e_ir);
         chk("m_tok_cnt", tok_cnt, m_cnt);
         if (e_ov) chk("m_out_data", out_data, mq[0].d);
         if (!pg_s) begin
            mq.delete();
         end else begin
            if (e_ov && out_ready) begin
               void'(mq.pop_front());
               m_cnt = m_cnt + 16'd1;
            end
            if (in_valid && e_ir) mq.push_back('{d: ref_of(in_data, in_inv), t: edge_n});
         end
      end
      edge_n++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input int n, input bit rnd);
      int   sent;
      logic acc;
      sent = 0;
      acc  = 1'b1;
      for (int g = 0; g < n + 2000 && sent < n; g++) begin
         in_valid = 1'b1;
         if (acc) begin
            in_data = ONE << $urandom_range(0, CH*W + 1);
            in_inv  = 1'($urandom_range(0, 1));
         end
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         acc = in_valid & in_ready;
         cyc();
         if (acc) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2*LV + 2) cyc();
      chk("stream_sent", sent, n);
   endtask

   logic [CH*W-1:0] bp_d[6];
   logic            bp_inv[6];
   logic [CH-1:0]   bp_exp[6];
   logic [CH-1:0]   rets[6];

   initial begin
      int   idx, nret, acc_early, n_ov;
      logic acc;

      rstn = 1'b0; vdd = 1'b1; vss = 1'b0;
      in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
      a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

      bp_d[0] = {5'b00001, 5'b00000}; bp_inv[0] = 1'b0; bp_exp[0] = 2'b10;
      bp_d[1] = {5'b00000, 5'b10000}; bp_inv[1] = 1'b0; bp_exp[1] = 2'b01;
      bp_d[2] = {5'b00100, 5'b01000}; bp_inv[2] = 1'b1; bp_exp[2] = 2'b00;
      bp_d[3] = {5'b00000, 5'b00000}; bp_inv[3] = 1'b1; bp_exp[3] = 2'b11;
      bp_d[4] = {5'b11111, 5'b00010}; bp_inv[4] = 1'b0; bp_exp[4] = 2'b11;
      bp_d[5] = {5'b00000, 5'b00000}; bp_inv[5] = 1'b0; bp_exp[5] = 2'b00;

      #1;
      chk("reset_out_valid_now", out_valid, 0);
      chk("reset_tok_cnt_now", tok_cnt, 0);
      repeat (3) cyc();

      // NOR tokens, first one accepted on the very first edge after release
      rstn = 1'b1;
      in_valid = 1'b1; in_data = {5'b00000, 5'b00000}; in_inv = 1'b1;
      cyc();
      in_data = {5'b10000, 5'b10000}; in_inv = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("nor_not_yet", out_valid, 0);
      cyc();
      chk("nor_t0_valid", out_valid, 1);
      chk("nor_t0_data", out_data, 2'b11);
      cyc();
      chk("nor_t1_valid", out_valid, 1);
      chk("nor_t1_data", out_data, 2'b00);
      cyc();
      chk("nor_drained", out_valid, 0);
      chk("nor_tok_cnt", tok_cnt, 2);

      // Mixed tokens with random downstream stalls
      stream(8, 1'b1);
      chk("mix_tok_cnt", tok_cnt, 10);

      // Backpressure: 5 stalled cycles, then drain
      idx = 0; nret = 0; acc_early = 0;
      for (int n = 0; n < 40 && nret < 6; n++) begin
         out_ready = (n >= 5);
         in_valid  = (idx < 6);
         in_data   = (idx < 6) ? bp_d[idx] : '0;
         in_inv    = (idx < 6) ? bp_inv[idx] : 1'b0;
         @(negedge clk);
         acc = in_valid & in_ready;
         if (out_valid && out_ready) begin
            rets[nret] = out_data;
            nret++;
         end
         if (n < 5 && acc) acc_early++;
         if (n == 4) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 2'b10);
            chk("bp_ready_low", in_ready, 0);
         end
         cyc();
         if (acc) idx++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_accepted_while_stalled", acc_early, LV);
      chk("bp_retired", nret, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("bp_result_%0d", i), rets[i], bp_exp[i]);
      repeat (2) cyc();
      chk("bp_tok_cnt", tok_cnt, 16);

      // Power loss with two tokens in flight
      in_valid = 1'b1; in_data = {5'b00001, 5'b00001}; in_inv = 1'b0;
      cyc();
      in_data = {5'b00000, 5'b00010};
      cyc();
      in_valid = 1'b0; vss = 1'b1;
      @(negedge clk);
      chk("pl_out_valid", out_valid, 0);
      chk("pl_in_ready", in_ready, 0);
      chk("pl_tok_cnt_hold", tok_cnt, 16);
      cyc();
      vss = 1'b0;
      n_ov = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) n_ov++;
      end
      chk("pl_no_stale", n_ov, 0);
      chk("pl_tok_cnt_after", tok_cnt, 16);
      cyc();

      // WIDTH=4 single lane latency
      a_in_valid = 1'b1; a_in_data = 4'b0100; a_in_inv = 1'b0; a_out_ready = 1'b1;
      cyc();
      a_in_valid = 1'b0;
      chk("w4_early", a_out_valid, 0);
      cyc();
      chk("w4_valid", a_out_valid, 1);
      chk("w4_data", a_out_data, 1);
      chk("w4_cnt_before", a_tok_cnt, 0);
      cyc();
      chk("w4_cnt_after", a_tok_cnt, 1);
      chk("w4_drained", a_out_valid, 0);

      // WIDTH=2 single stage, stall then simultaneous accept and retire
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 2'b10; b_in_inv = 1'b1;
      #1;
      chk("w2_ready_empty", b_in_ready, 1);
      cyc();
      chk("w2_valid", b_out_valid, 1);
      chk("w2_data0", b_out_data, 0);
      chk("w2_ready_full", b_in_ready, 0);
      b_in_data = 2'b00; b_in_inv = 1'b1;
      cyc();
      chk("w2_hold", b_out_data, 0);
      b_out_ready = 1'b1;
      #1;
      chk("w2_ready_pass", b_in_ready, 1);
      cyc();
      b_in_valid = 1'b0;
      chk("w2_data1", b_out_data, 1);
      chk("w2_cnt1", b_tok_cnt, 1);
      cyc();
      chk("w2_cnt2", b_tok_cnt, 2);
      chk("w2_drained", b_out_valid, 0);

      // Counter wrap from a clean reset
      rstn = 1'b0;
      repeat (2) cyc();
      rstn = 1'b1;
      stream(65535, 1'b0);
      chk("wrap_ffff", tok_cnt, 16'hFFFF);
      stream(1, 1'b0);
      chk("wrap_zero", tok_cnt, 16'h0000);

      // Reset in the middle of a stream
      in_valid = 1'b1; in_data = {5'b00000, 5'b00100}; in_inv = 1'b0; out_ready = 1'b1;
      repeat (4) cyc();
      chk("mid_valid_before", out_valid, 1);
      chk("mid_cnt_before", tok_cnt, 1);
      rstn = 1'b0;
      #1;
      chk("mid_out_valid_now", out_valid, 0);
      chk("mid_tok_cnt_now", tok_cnt, 0);
      chk("mid_in_ready_now", in_ready, 0);
      in_valid = 1'b0;
      cyc();
      cyc();
      rstn = 1'b1;
      n_ov = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) n_ov++;
      end
      chk("mid_no_survivor", n_ov, 0);
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/or_tree_pipe.md
OR_TREE_PIPE -- requirements
Module: or_tree_pipe

Interface
REQ-001 Parameter WIDTH, default 4: input bits per channel OR-reduced; SHALL be legal for 2..64.
REQ-002 Parameter CHANNELS, default 1: independent reduction lanes; SHALL be legal for 1..16.
REQ-003 Parameter LEVELS, derived as ceil(log2(WIDTH)): pipeline depth; SHALL NOT be overridden.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-005 Port: clkpos  input  1  the one clock; all state updates on its rising edge.
REQ-006 Port: rstn  input  1  asynchronous active-low reset.
REQ-007 Port: vdd  input  1  supply-good rail; 1 = powered.
REQ-008 Port: vss  input  1  ground rail; 0 = powered.
REQ-009 Port: in_valid  input  1  input token present.
REQ-010 Port: in_ready  output  1  pipeline accepts a token this cycle.
REQ-011 Port: in_data  input  CHANNELS*WIDTH  operands; lane c occupies bits [c*WIDTH +: WIDTH].
REQ-012 Port: in_inv  input  1  per-token mode: 0 = OR, 1 = NOR (the b-polarity output).
REQ-013 Port: out_valid  output  1  result token present.
REQ-014 Port: out_ready  input  1  downstream accepts result.
REQ-015 Port: out_data  output  CHANNELS  one reduced bit per lane.
REQ-016 Port: tok_cnt  output  16  count of tokens delivered at the output.

Function
REQ-017 Power-good SHALL be pg = vdd & ~vss, sampled each cycle.
REQ-018 Stage k (1..LEVELS) SHALL hold ceil(WIDTH/2^k) partial ORs per lane, a valid bit, and the token's in_inv bit.
- Odd-count levels pass the unpaired bit through unchanged.
REQ-019 Input handshake: a token SHALL transfer when in_valid & in_ready on a rising edge.
REQ-020 Output handshake: a token SHALL retire when out_valid & out_ready on a rising edge.
REQ-021 Each stage SHALL advance when its successor is empty or advancing (elastic pipeline, no bubbles required).
- in_ready = pg & (stage 1 empty or stage 1 advancing); SHALL be combinational.
REQ-022 Latency with out_ready held high SHALL be exactly LEVELS cycles, from acceptance to out_valid.
- Throughput SHALL be one token per cycle.
REQ-023 out_data[c] SHALL equal (|lane c) XOR inv, where inv is the bit captured with that token.
- Mixed OR/NOR tokens SHALL coexist in flight without cross-contamination.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
- Upstream stages SHALL fill; in_ready SHALL drop only once all LEVELS stages are full.
REQ-025 Simultaneous accept and retire with a full pipeline SHALL be lossless: in_ready stays 1 when out_ready=1.
REQ-026 When pg=0 on a rising edge, all stage valid bits SHALL clear (flush).
- While pg=0: in_ready=0, out_valid=0; tok_cnt SHALL hold.
- Data registers need not clear on flush.
REQ-027 tok_cnt SHALL increment by 1 per retired token and wrap 0xFFFF -> 0x0000.
REQ-028 WIDTH=2 SHALL give LEVELS=1; all behaviour above SHALL hold with a single stage.

Reset
REQ-029 rstn=0 SHALL immediately, without waiting for a clock edge, clear all valid bits, data registers, inv bits and tok_cnt.
- Outputs during and after reset: out_valid=0, out_data=0, tok_cnt=0; in_ready=0 while rstn=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight tokens; none SHALL appear after release.
REQ-031 The first acceptance SHALL be possible on the first rising edge after rstn rises, with pg=1.

Verification
REQ-032 Latency: WIDTH=4, out_ready=1, in_data=4'b0100, in_inv=0 -> out_valid=1, out_data=1 exactly 2 cycles later; tok_cnt=1 one cycle after retire.
REQ-033 NOR mode: WIDTH=5 (LEVELS=3), in_data=5'b00000, in_inv=1 -> out_data=1 after 3 cycles; next token 5'b10000, inv=1 -> out_data=0.
REQ-034 Backpressure: CHANNELS=2, stream 6 tokens, out_ready=0 for 5 cycles -> in_ready falls after LEVELS tokens, output held stable, all 6 results in order and correct after out_ready=1.
REQ-035 Power loss: 2 tokens in flight, vss=1 for one cycle -> out_valid=0, in_ready=0 that cycle; no stale result after pg returns; tok_cnt unchanged.
REQ-036 Reset and wrap: force 65535 retirements, then one more -> tok_cnt=0x0000; assert rstn=0 mid-stream -> out_valid=0 immediately; no token emerges after release.
